// File: rtl/seg_7_pkg.sv
// rtl/seg_7_pkg.sv - shared seven-segment pattern constants and code types
//
// Purpose: active-low segment patterns (bit0=a .. bit6=g) for the sixteen hex
// glyphs plus the all-off blank pattern, and the 5-bit sample code used by the
// scan decoder's per-digit stability filter.
// Ports: none (package).

package seg_7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Sample code: 0..15 hex value, 16 blank, 31 "no previous sample".
  typedef logic [4:0] code_t;

  localparam code_t CODE_BLANK = 5'd16;
  localparam code_t CODE_NONE  = 5'd31;

endpackage

// File: rtl/seg_7_pattern_match.sv
// rtl/seg_7_pattern_match.sv - combinational seven-segment pattern recogniser
//
// Purpose: classify one active-low segment pattern as a hex glyph, blank, or
// unrecognised.
// Ports:
//   seg   in  7  active-low segment lines, bit0=a .. bit6=g
//   hit   out 1  pattern is one of the sixteen hex glyphs
//   blank out 1  pattern is all segments off
//   value out 4  hex value when hit, else 0
// hit=0 and blank=0 together mean an unrecognised pattern.

module seg_7_pattern_match
  import seg_7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic       blank,
  output logic [3:0] value
);

  always_comb begin
    hit   = 1'b1;
    blank = 1'b0;
    value = 4'h0;
    case (seg)
      SEG_0:     value = 4'h0;
      SEG_1:     value = 4'h1;
      SEG_2:     value = 4'h2;
      SEG_3:     value = 4'h3;
      SEG_4:     value = 4'h4;
      SEG_5:     value = 4'h5;
      SEG_6:     value = 4'h6;
      SEG_7:     value = 4'h7;
      SEG_8:     value = 4'h8;
      SEG_9:     value = 4'h9;
      SEG_A:     value = 4'hA;
      SEG_B:     value = 4'hB;
      SEG_C:     value = 4'hC;
      SEG_D:     value = 4'hD;
      SEG_E:     value = 4'hE;
      SEG_F:     value = 4'hF;
      SEG_BLANK: begin
        hit   = 1'b0;
        blank = 1'b1;
      end
      default:   hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_7_scan_decode.sv
// rtl/seg_7_scan_decode.sv - recovers hex digits from a multiplexed 7-seg bus
//
// Purpose: register the scanned display bus, take one sample per digit
// selection, filter each digit over STABLE_CNT matching samples, hold the
// committed values and report every change as a valid/ready event.
// Ports:
//   clk        in  1         rising-edge clock
//   rst        in  1         synchronous active-high reset
//   an         in  DIGITS    active-low digit enables (one low bit = valid)
//   seg        in  7         active-low segment lines
//   digits     out 4*DIGITS  committed hex values, nibble i = digit i
//   digit_ok   out DIGITS    digit i holds a committed hex value
//   out_valid  out 1         event available
//   out_ready  in  1         event consumed when out_valid & out_ready
//   out_index  out 3         digit position of the event
//   out_digit  out 4         committed value of that digit (0 when blank)
//   out_blank  out 1         event reports the digit going blank
//   pat_err    out 1         one-cycle pulse on an unrecognised sample

module seg_7_scan_decode
  import seg_7_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int STABLE_CNT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     an,
  input  logic [6:0]            seg,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     digit_ok,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2:0]            out_index,
  output logic [3:0]            out_digit,
  output logic                  out_blank,
  output logic                  pat_err
);

  localparam logic [3:0] STAB_MAX = 4'(STABLE_CNT);

  // Input capture and dwell tracking
  logic [DIGITS-1:0] an_q;
  logic [DIGITS-1:0] an_last;
  logic [6:0]        seg_q;
  logic [1:0]        dwell_q;
  logic [1:0]        dwell_d;
  logic              an_valid;
  logic              sample;

  // Decoded sample
  logic              hit;
  logic              blank;
  logic [3:0]        value;
  code_t             cur_code;
  logic              is_err;

  // Per-digit filter and committed state
  logic [DIGITS-1:0][3:0] stab_q;
  logic [DIGITS-1:0][3:0] stab_d;
  code_t [DIGITS-1:0]     last_q;
  code_t [DIGITS-1:0]     last_d;
  code_t [DIGITS-1:0]     comm_code;
  logic [4*DIGITS-1:0]    digits_q;
  logic [4*DIGITS-1:0]    digits_d;
  logic [DIGITS-1:0]      ok_q;
  logic [DIGITS-1:0]      ok_d;
  logic [DIGITS-1:0]      commit;

  // Event arbitration
  logic [DIGITS-1:0]      pending_q;
  logic [DIGITS-1:0]      pending_d;
  logic [DIGITS-1:0]      load_mask;
  logic                   can_load;
  logic                   any_pending;
  logic [2:0]             pick_idx;
  logic [3:0]             pick_nib;
  logic                   pick_blank;

  seg_7_pattern_match u_match (
    .seg   (seg_q),
    .hit   (hit),
    .blank (blank),
    .value (value)
  );

  // The dwell count is the number of cycles the current selection has been
  // held beyond its first; it saturates at 3 since only the value 1 matters.
  // Comparing against an_last (the previous an_q) means a return to the same
  // digit after an invalid gap still starts a fresh dwell.
  always_comb begin
    an_valid = $onehot(~an_q);
    dwell_d  = 2'd0;
    if (an_valid && (an_q == an_last)) begin
      dwell_d = (dwell_q == 2'd3) ? 2'd3 : dwell_q + 2'd1;
    end
    sample   = (dwell_d == 2'd1);
    cur_code = hit ? {1'b0, value} : CODE_BLANK;
    is_err   = !hit && !blank;
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      comm_code[i] = ok_q[i] ? {1'b0, digits_q[4*i +: 4]} : CODE_BLANK;
    end
  end

  always_comb begin
    stab_d   = stab_q;
    last_d   = last_q;
    digits_d = digits_q;
    ok_d     = ok_q;
    commit   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sample && !an_q[i]) begin
        if (is_err) begin
          stab_d[i] = 4'd0;
          last_d[i] = CODE_NONE;
        end else begin
          if (cur_code == last_q[i]) begin
            stab_d[i] = (stab_q[i] >= STAB_MAX) ? STAB_MAX : stab_q[i] + 4'd1;
          end else begin
            last_d[i] = cur_code;
            stab_d[i] = 4'd1;
          end
          // Saturated repeats of the committed code fall through the
          // inequality test, so a stable digit never re-announces itself.
          if ((stab_d[i] == STAB_MAX) && (cur_code != comm_code[i])) begin
            commit[i]            = 1'b1;
            ok_d[i]              = hit;
            digits_d[4*i +: 4]   = hit ? value : 4'h0;
          end
        end
      end
    end
  end

  // Lowest pending index wins. The event reads the registered (pre-commit)
  // state; a same-cycle commit on that digit re-sets its pending bit so the
  // newer value is reported afterwards.
  always_comb begin
    any_pending = |pending_q;
    can_load    = !out_valid || out_ready;
    pick_idx    = 3'd0;
    pick_nib    = 4'h0;
    pick_blank  = 1'b0;
    load_mask   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        pick_idx     = 3'(i);
        pick_nib     = digits_q[4*i +: 4];
        pick_blank   = !ok_q[i];
        load_mask    = '0;
        load_mask[i] = 1'b1;
      end
    end
    if (can_load) begin
      pending_d = (pending_q & ~load_mask) | commit;
    end else begin
      pending_d = pending_q | commit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q      <= '1;
      an_last   <= '1;
      seg_q     <= SEG_BLANK;
      dwell_q   <= 2'd0;
      stab_q    <= '0;
      last_q    <= {DIGITS{CODE_NONE}};
      digits_q  <= '0;
      ok_q      <= '0;
      pending_q <= '0;
      out_valid <= 1'b0;
      out_index <= 3'd0;
      out_digit <= 4'h0;
      out_blank <= 1'b0;
      pat_err   <= 1'b0;
    end else begin
      an_q      <= an;
      an_last   <= an_q;
      seg_q     <= seg;
      dwell_q   <= dwell_d;
      stab_q    <= stab_d;
      last_q    <= last_d;
      digits_q  <= digits_d;
      ok_q      <= ok_d;
      pending_q <= pending_d;
      pat_err   <= sample && is_err;
      if (can_load) begin
        out_valid <= any_pending;
        if (any_pending) begin
          out_index <= pick_idx;
          out_digit <= pick_nib;
          out_blank <= pick_blank;
        end
      end
    end
  end

  assign digits   = digits_q;
  assign digit_ok = ok_q;

endmodule

// File: tb/tb_seg_7_scan_decode.sv
// tb/tb_seg_7_scan_decode.sv - self-checking bench for seg_7_scan_decode

module tb_seg_7_scan_decode;

  localparam int ND = 8;
  localparam int SC = 3;
  localparam logic [6:0] BAD = 7'b0110110;
  localparam logic [6:0] OFF = 7'b1111111;

  logic           clk = 1'b0;
  logic           rst;
  logic [ND-1:0]  an;
  logic [6:0]     seg;
  logic [4*ND-1:0] digits;
  logic [ND-1:0]  digit_ok;
  logic           out_valid;
  logic           out_ready;
  logic [2:0]     out_index;
  logic [3:0]     out_digit;
  logic           out_blank;
  logic           pat_err;

  always #5 clk = ~clk;

  seg_7_scan_decode #(.DIGITS(ND), .STABLE_CNT(SC)) dut (
    .clk       (clk),
    .rst       (rst),
    .an        (an),
    .seg       (seg),
    .digits    (digits),
    .digit_ok  (digit_ok),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_digit (out_digit),
    .out_blank (out_blank),
    .pat_err   (pat_err)
  );

  typedef struct {
    int idx;
    int dig;
    int blank;
  } ev_t;

  int checks = 0;
  int errors = 0;

  logic [6:0] hex_pat [16];
  ev_t obs_q[$];
  ev_t exp_q[$];
  int  perr_cnt;
  int  exp_perr;

  // Reference model: per digit, last code (-1 = none), run length, committed
  // code (16 = blank). Updated once per dwell of two or more cycles.
  int m_last [ND];
  int m_cnt  [ND];
  int m_comm [ND];

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        ev_t e;
        e.idx   = int'(out_index);
        e.dig   = int'(out_digit);
        e.blank = int'(out_blank);
        obs_q.push_back(e);
      end
      if (pat_err) perr_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  function automatic int decode(logic [6:0] p);
    for (int k = 0; k < 16; k++) if (p == hex_pat[k]) return k;
    if (p == OFF) return 16;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      m_last[i] = -1;
      m_cnt[i]  = 0;
      m_comm[i] = 16;
    end
    exp_q.delete();
    exp_perr = 0;
  endtask

  task automatic model_sample(int d, logic [6:0] p);
    int c;
    ev_t e;
    c = decode(p);
    if (c < 0) begin
      exp_perr++;
      m_cnt[d]  = 0;
      m_last[d] = -1;
    end else begin
      if (c == m_last[d]) m_cnt[d] = (m_cnt[d] + 1 > SC) ? SC : m_cnt[d] + 1;
      else begin
        m_last[d] = c;
        m_cnt[d]  = 1;
      end
      if (m_cnt[d] == SC && c != m_comm[d]) begin
        m_comm[d] = c;
        e.idx   = d;
        e.dig   = (c == 16) ? 0 : c;
        e.blank = (c == 16) ? 1 : 0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dwell(int d, logic [6:0] p, int len);
    an  = ~(8'b1 << d);
    seg = p;
    repeat (len) tick();
    if (len >= 2) model_sample(d, p);
  endtask

  task automatic idle(int n);
    an  = '1;
    seg = OFF;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    an  = '1;
    seg = OFF;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    obs_q.delete();
    perr_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (digits !== '0) begin errors++; $display("FAIL reset_digits: got %h want 0", digits); end
    checks++; if (digit_ok !== '0) begin errors++; $display("FAIL reset_ok: got %b want 0", digit_ok); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if ({out_index, out_digit, out_blank} !== 8'h0) begin errors++;
      $display("FAIL reset_event: got %0d/%0d/%0d want 0/0/0", out_index, out_digit, out_blank); end
    checks++; if (pat_err !== 1'b0) begin errors++; $display("FAIL reset_pat_err: got %b want 0", pat_err); end
  endtask

  task automatic test_single_digit();
    obs_q.delete();
    repeat (3) begin
      dwell(2, hex_pat[2], 4);
      dwell(0, OFF, 4);
      dwell(1, OFF, 4);
      dwell(3, OFF, 4);
    end
    idle(6);
    checks++; if (digits[11:8] !== 4'h2) begin errors++; $display("FAIL single_nibble: got %h want 2", digits[11:8]); end
    checks++; if (digit_ok !== 8'b0000_0100) begin errors++; $display("FAIL single_ok: got %b want 00000100", digit_ok); end
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", obs_q.size()); end
    checks++;
    if (obs_q.size() < 1) begin errors++; $display("FAIL single_event: got none want 2/2/0"); end
    else if (obs_q[0].idx != 2 || obs_q[0].dig != 2 || obs_q[0].blank != 0) begin errors++;
      $display("FAIL single_event: got %0d/%0d/%0d want 2/2/0", obs_q[0].idx, obs_q[0].dig, obs_q[0].blank); end
    repeat (10) begin
      dwell(2, hex_pat[2], 3);
      dwell(0, OFF, 3);
    end
    idle(6);
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL repeat_count: got %0d want 1", obs_q.size()); end
  endtask

  task automatic test_back_to_back();
    obs_q.delete();
    out_ready = 1'b0;
    repeat (3) begin dwell(1, hex_pat[7], 3); dwell(0, OFF, 2); end
    repeat (3) begin dwell(5, hex_pat[10], 3); dwell(0, OFF, 2); end
    idle(2);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_index !== 3'd1 || out_digit !== 4'h7 || out_blank !== 1'b0) begin errors++;
        $display("FAIL hold_%0d: got v%b %0d/%0d/%0d want v1 1/7/0", k, out_valid, out_index, out_digit, out_blank); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_index !== 3'd5 || out_digit !== 4'hA || out_blank !== 1'b0) begin errors++;
      $display("FAIL follow: got v%b %0d/%0d/%0d want v1 5/10/0", out_valid, out_index, out_digit, out_blank); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain: got %b want 0", out_valid); end
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", obs_q.size()); end
  endtask

  task automatic test_blank();
    obs_q.delete();
    repeat (3) begin dwell(3, hex_pat[7], 3); dwell(6, OFF, 2); end
    repeat (3) begin dwell(3, OFF, 3); dwell(6, OFF, 2); end
    idle(6);
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL blank_count: got %0d want 2", obs_q.size()); end
    checks++;
    if (obs_q.size() < 2) begin errors++; $display("FAIL blank_event: missing want 3/0/1"); end
    else if (obs_q[0].idx != 3 || obs_q[0].dig != 7 || obs_q[0].blank != 0 ||
             obs_q[1].idx != 3 || obs_q[1].dig != 0 || obs_q[1].blank != 1) begin errors++;
      $display("FAIL blank_event: got %0d/%0d/%0d %0d/%0d/%0d want 3/7/0 3/0/1", obs_q[0].idx, obs_q[0].dig,
               obs_q[0].blank, obs_q[1].idx, obs_q[1].dig, obs_q[1].blank); end
    checks++; if (digit_ok[3] !== 1'b0 || digits[15:12] !== 4'h0) begin errors++;
      $display("FAIL blank_state: got ok%b %h want ok0 0", digit_ok[3], digits[15:12]); end
  endtask

  task automatic test_pat_err();
    obs_q.delete();
    perr_cnt = 0;
    repeat (2) begin dwell(0, hex_pat[9], 3); dwell(6, OFF, 2); end
    repeat (4) begin dwell(0, BAD, 3); dwell(6, OFF, 2); end
    idle(4);
    checks++; if (perr_cnt != 4) begin errors++; $display("FAIL pat_err_count: got %0d want 4", perr_cnt); end
    repeat (2) begin dwell(0, hex_pat[9], 3); dwell(6, OFF, 2); end
    idle(6);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL restart_early: got %0d events want 0", obs_q.size()); end
    dwell(0, hex_pat[9], 3);
    idle(6);
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL restart_commit: got %0d events want 1", obs_q.size()); end
    else if (obs_q[0].idx != 0 || obs_q[0].dig != 9 || obs_q[0].blank != 0) begin errors++;
      $display("FAIL restart_commit: got %0d/%0d/%0d want 0/9/0", obs_q[0].idx, obs_q[0].dig, obs_q[0].blank); end
  endtask

  task automatic test_single_cycle();
    obs_q.delete();
    perr_cnt = 0;
    for (int k = 0; k < 48; k++) begin
      an  = ~(8'b1 << (k % 8));
      seg = (k % 2 == 1) ? BAD : hex_pat[4];
      tick();
    end
    idle(6);
    checks++; if (perr_cnt != 0) begin errors++; $display("FAIL toggle_pat_err: got %0d want 0", perr_cnt); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL toggle_events: got %0d want 0", obs_q.size()); end
  endtask

  task automatic test_random();
    int prev;
    int d;
    int tgt [ND];
    logic [6:0] p;
    int k;
    do_reset();
    out_ready = 1'b1;
    prev = -1;
    for (int i = 0; i < ND; i++) tgt[i] = $urandom_range(0, 16);
    for (int n = 0; n < 320; n++) begin
      d = $urandom_range(0, ND - 1);
      if (d == prev) d = (d + 1) % ND;
      if ($urandom_range(0, 3) == 0) tgt[d] = $urandom_range(0, 16);
      k = tgt[d];
      p = (k == 16) ? OFF : hex_pat[k];
      if ($urandom_range(0, 11) == 0) p = BAD;
      dwell(d, p, $urandom_range(1, 4));
      prev = d;
      if ($urandom_range(0, 9) == 0) begin
        an  = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'b1110_0111;
        seg = hex_pat[1];
        tick();
        prev = -1;
      end
    end
    idle(8);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++;
      $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].idx != exp_q[i].idx || obs_q[i].dig != exp_q[i].dig || obs_q[i].blank != exp_q[i].blank) begin
        errors++;
        $display("FAIL rand_event_%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i, obs_q[i].idx, obs_q[i].dig,
                 obs_q[i].blank, exp_q[i].idx, exp_q[i].dig, exp_q[i].blank);
      end
    end
    checks++; if (perr_cnt != exp_perr) begin errors++; $display("FAIL rand_pat_err: got %0d want %0d", perr_cnt, exp_perr); end
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (digit_ok[i] !== (m_comm[i] != 16) || int'(digits[4*i +: 4]) != ((m_comm[i] == 16) ? 0 : m_comm[i])) begin
        errors++;
        $display("FAIL rand_digit_%0d: got ok%b %h want code %0d", i, digit_ok[i], digits[4*i +: 4], m_comm[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    repeat (3) begin dwell(4, hex_pat[3], 3); dwell(7, OFF, 2); end
    repeat (3) begin dwell(6, hex_pat[12], 3); dwell(7, OFF, 2); end
    checks++; if (out_valid !== 1'b1 || out_index !== 3'd4) begin errors++;
      $display("FAIL mid_pre: got v%b idx %0d want v1 idx 4", out_valid, out_index); end
    an  = ~8'b0001_0000;
    seg = hex_pat[3];
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || {out_index, out_digit, out_blank} !== 8'h0 || digits !== '0 ||
        digit_ok !== '0 || pat_err !== 1'b0) begin errors++;
      $display("FAIL mid_reset: got v%b %0d/%0d/%0d digits %h ok %b err %b want all 0", out_valid, out_index,
               out_digit, out_blank, digits, digit_ok, pat_err); end
    rst = 1'b0;
    out_ready = 1'b1;
    idle(6);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_after: got %b want 0", out_valid); end
  endtask

  initial begin
    hex_pat[0]  = 7'b1000000; hex_pat[1]  = 7'b1111001; hex_pat[2]  = 7'b0100100; hex_pat[3]  = 7'b0110000;
    hex_pat[4]  = 7'b0011001; hex_pat[5]  = 7'b0010010; hex_pat[6]  = 7'b0000010; hex_pat[7]  = 7'b1111000;
    hex_pat[8]  = 7'b0000000; hex_pat[9]  = 7'b0010000; hex_pat[10] = 7'b0001000; hex_pat[11] = 7'b0000011;
    hex_pat[12] = 7'b1000110; hex_pat[13] = 7'b0100001; hex_pat[14] = 7'b0000110; hex_pat[15] = 7'b0001110;
    rst       = 1'b1;
    an        = '1;
    seg       = OFF;
    out_ready = 1'b1;
    perr_cnt  = 0;
    test_reset();
    test_single_digit();
    test_back_to_back();
    test_blank();
    test_pat_err();
    test_single_cycle();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
